// File: rtl/vga_stream_pkg.sv
// vga_stream_pkg
//   Shared types and constants for the VGA output stream path.
//   - arb_state_t : frame arbiter FSM states (IDLE, STREAM, PAD)
//   - DEF_*       : default frame geometry and pixel width
//   - BLACK_PIXEL : pixel value used to pad short frames
//   - frame_last  : index of the final pixel of a WIDTH x HEIGHT frame
package vga_stream_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    PAD
  } arb_state_t;

  localparam int unsigned DEF_WIDTH  = 640;
  localparam int unsigned DEF_HEIGHT = 480;
  localparam int unsigned DEF_DATA_W = 30;

  localparam logic [DEF_DATA_W-1:0] BLACK_PIXEL = '0;

  function automatic int unsigned frame_last(input int unsigned w, input int unsigned h);
    return w * h - 1;
  endfunction

endpackage

// File: rtl/frame_pixel_counter.sv
// frame_pixel_counter
//   Counts output pixels within one frame.
//   Ports:
//     clk      in   system clock
//     reset    in   synchronous active-low reset
//     inc      in   advance to the next pixel
//     clr      in   return to pixel 0 (wins over inc)
//     cnt      out  current pixel index
//     is_first out  cnt is the first pixel of the frame
//     is_last  out  cnt is the last pixel of the frame
module frame_pixel_counter
  import vga_stream_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned HEIGHT = DEF_HEIGHT,
  parameter int unsigned CNT_W  = $clog2(WIDTH * HEIGHT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             is_first,
  output logic             is_last
);

  localparam int unsigned LAST = frame_last(WIDTH, HEIGHT);

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_comb begin
    is_first = (cnt == '0);
    is_last  = (cnt == CNT_W'(LAST));
  end

endmodule

// File: rtl/frame_stream_arbiter.sv
// frame_stream_arbiter
//   Grants the VGA output stream to one of two Avalon-ST pixel sources,
//   switching only between frames. Output framing is regenerated from an
//   internal pixel counter; short frames are padded with black pixels and
//   long frames are truncated, so every output packet is WIDTH*HEIGHT beats.
//   Ports:
//     clk, reset                  clock, synchronous active-low reset
//     sel_req                     requested source (0 = src0, 1 = src1)
//     srcN_data/valid/sop/eop     source N stream
//     srcN_ready                  beat accepted from source N
//     out_data/valid/sop/eop      output stream to the VGA consumer
//     out_ready                   downstream ready
//     active_src                  currently granted source
//     frame_count                 completed output frames (wraps)
//     err_frame                   one-cycle pulse on a malformed source frame
module frame_stream_arbiter
  import vga_stream_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned HEIGHT = DEF_HEIGHT,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sel_req,
  input  logic [DATA_W-1:0] src0_data,
  input  logic              src0_valid,
  input  logic              src0_sop,
  input  logic              src0_eop,
  output logic              src0_ready,
  input  logic [DATA_W-1:0] src1_data,
  input  logic              src1_valid,
  input  logic              src1_sop,
  input  logic              src1_eop,
  output logic              src1_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_sop,
  output logic              out_eop,
  input  logic              out_ready,
  output logic              active_src,
  output logic [15:0]       frame_count,
  output logic              err_frame
);

  localparam int unsigned CNT_W = $clog2(WIDTH * HEIGHT);

  arb_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic              is_first;
  logic              is_last;

  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_sop;
  logic              s_eop;
  logic              sel_ready;
  logic              mid_sop;
  logic              ohs;
  logic              frame_done;

  always_comb begin
    s_data  = active_src ? src1_data  : src0_data;
    s_valid = active_src ? src1_valid : src0_valid;
    s_sop   = active_src ? src1_sop   : src0_sop;
    s_eop   = active_src ? src1_eop   : src0_eop;
  end

  // A sop arriving anywhere but pixel 0 starts the next frame: leave it
  // unconsumed for IDLE and pad out the current one.
  assign mid_sop = (state == STREAM) && s_valid && s_sop && (cnt != '0);

  always_comb begin
    out_valid = 1'b0;
    out_data  = DATA_W'(BLACK_PIXEL);
    sel_ready = 1'b0;
    case (state)
      IDLE: begin
        sel_ready = ~s_sop;
      end
      STREAM: begin
        out_valid = s_valid & ~mid_sop;
        out_data  = s_data;
        sel_ready = out_ready & ~mid_sop;
      end
      PAD: begin
        out_valid = 1'b1;
      end
      default: begin
        out_valid = 1'b0;
      end
    endcase
    if (!reset) begin
      out_valid = 1'b0;
      sel_ready = 1'b0;
    end
  end

  assign src0_ready = sel_ready & ~active_src;
  assign src1_ready = sel_ready &  active_src;

  assign out_sop    = out_valid & is_first;
  assign out_eop    = out_valid & is_last;

  assign ohs        = out_valid & out_ready;
  assign frame_done = ohs & is_last;

  frame_pixel_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .CNT_W  (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .inc      (ohs),
    .clr      (frame_done),
    .cnt      (cnt),
    .is_first (is_first),
    .is_last  (is_last)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      active_src  <= 1'b0;
      frame_count <= '0;
      err_frame   <= 1'b0;
    end else begin
      err_frame <= 1'b0;
      case (state)
        IDLE: begin
          // Grant is frozen on the cycle the sop is seen so STREAM reads
          // the same source that produced it.
          if (s_valid && s_sop) begin
            state <= STREAM;
          end else begin
            active_src <= sel_req;
          end
        end
        STREAM: begin
          if (mid_sop) begin
            state     <= PAD;
            err_frame <= 1'b1;
          end else if (ohs) begin
            if (is_last) begin
              state       <= IDLE;
              frame_count <= frame_count + 16'd1;
              active_src  <= sel_req;
              err_frame   <= ~s_eop;
            end else if (s_eop) begin
              state     <= PAD;
              err_frame <= 1'b1;
            end
          end
        end
        PAD: begin
          if (frame_done) begin
            state       <= IDLE;
            frame_count <= frame_count + 16'd1;
            active_src  <= sel_req;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_stream_arbiter.sv
// tb_frame_stream_arbiter
//   Directed bench for frame_stream_arbiter at WIDTH=4, HEIGHT=2.
//   Sources are driven from beat queues; a frame-level reference model in
//   the bench predicts every output each cycle, and scenario-end literals
//   pin captured output beats.
module tb_frame_stream_arbiter;

  localparam int W     = 4;
  localparam int H     = 2;
  localparam int DW    = 30;
  localparam int LASTI = W * H - 1;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
  } beat_t;

  logic          clk;
  logic          reset;
  logic          sel_req;
  logic [DW-1:0] src0_data, src1_data;
  logic          src0_valid, src0_sop, src0_eop, src0_ready;
  logic          src1_valid, src1_sop, src1_eop, src1_ready;
  logic [DW-1:0] out_data;
  logic          out_valid, out_sop, out_eop, out_ready;
  logic          active_src;
  logic [15:0]   frame_count;
  logic          err_frame;

  frame_stream_arbiter #(
    .WIDTH  (W),
    .HEIGHT (H),
    .DATA_W (DW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sel_req     (sel_req),
    .src0_data   (src0_data),
    .src0_valid  (src0_valid),
    .src0_sop    (src0_sop),
    .src0_eop    (src0_eop),
    .src0_ready  (src0_ready),
    .src1_data   (src1_data),
    .src1_valid  (src1_valid),
    .src1_sop    (src1_sop),
    .src1_eop    (src1_eop),
    .src1_ready  (src1_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_sop     (out_sop),
    .out_eop     (out_eop),
    .out_ready   (out_ready),
    .active_src  (active_src),
    .frame_count (frame_count),
    .err_frame   (err_frame)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int    n_cmp  = 0;
  int    n_fail = 0;

  beat_t q0[$];
  beat_t q1[$];
  beat_t got[$];

  // Reference model state: frame in progress, padding, output pixel index,
  // granted source, completed frames, pending error pulse.
  bit    m_busy = 0;
  bit    m_pad  = 0;
  int    m_pos  = 0;
  bit    m_act  = 0;
  int    m_fc   = 0;
  bit    m_err  = 0;

  bit    acc0, acc1;
  bit    bp_on = 0;
  int    pat_idx = 0;
  bit    rdy_seq [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  int    err_seen = 0;
  bit    prev_stall = 0;
  logic [DW-1:0] prev_data = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  task automatic drive();
    if (q0.size() > 0) begin
      src0_valid = 1'b1; src0_data = q0[0].data; src0_sop = q0[0].sop; src0_eop = q0[0].eop;
    end else begin
      src0_valid = 1'b0; src0_data = '0; src0_sop = 1'b0; src0_eop = 1'b0;
    end
    if (q1.size() > 0) begin
      src1_valid = 1'b1; src1_data = q1[0].data; src1_sop = q1[0].sop; src1_eop = q1[0].eop;
    end else begin
      src1_valid = 1'b0; src1_data = '0; src1_sop = 1'b0; src1_eop = 1'b0;
    end
  endtask

  task automatic push_frame(input int src, input int n, input int base, input int eop_at);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.data = DW'(base + i);
      b.sop  = (i == 0);
      b.eop  = (i == eop_at);
      if (src == 0) q0.push_back(b);
      else          q1.push_back(b);
    end
    drive();
  endtask

  // One clock: compare at negedge against the model, advance the model,
  // then update the sources after the posedge.
  task automatic tick();
    logic          sv, ssop, seop, clash, e_ov, e_rdy, ohs_m;
    logic [DW-1:0] sdat, e_data;
    @(negedge clk);
    sv   = m_act ? src1_valid : src0_valid;
    ssop = m_act ? src1_sop   : src0_sop;
    seop = m_act ? src1_eop   : src0_eop;
    sdat = m_act ? src1_data  : src0_data;
    clash  = 1'b0;
    e_data = '0;
    if (!m_busy) begin
      e_ov  = 1'b0;
      e_rdy = ~ssop;
    end else if (m_pad) begin
      e_ov  = 1'b1;
      e_rdy = 1'b0;
    end else begin
      clash  = sv & ssop & (m_pos != 0);
      e_ov   = sv & ~clash;
      e_rdy  = out_ready & ~clash;
      e_data = sdat;
    end
    if (!reset) begin
      e_ov  = 1'b0;
      e_rdy = 1'b0;
    end
    check("out_valid", 64'(out_valid), 64'(e_ov));
    check("src0_ready", 64'(src0_ready), 64'(e_rdy & ~m_act));
    check("src1_ready", 64'(src1_ready), 64'(e_rdy & m_act));
    if (e_ov) begin
      check("out_data", 64'(out_data), 64'(e_data));
      check("out_sop", 64'(out_sop), 64'(m_pos == 0));
      check("out_eop", 64'(out_eop), 64'(m_pos == LASTI));
    end
    check("active_src", 64'(active_src), 64'(m_act));
    check("frame_count", 64'(frame_count), 64'(m_fc));
    check("err_frame", 64'(err_frame), 64'(m_err));
    if (prev_stall && out_valid) check("stall_hold", 64'(out_data), 64'(prev_data));
    prev_stall = reset & out_valid & ~out_ready;
    prev_data  = out_data;

    if (out_valid && out_ready) got.push_back('{out_data, out_sop, out_eop});
    if (err_frame) err_seen++;
    acc0 = src0_valid & src0_ready;
    acc1 = src1_valid & src1_ready;

    if (!reset) begin
      m_busy = 0; m_pad = 0; m_pos = 0; m_act = 0; m_fc = 0; m_err = 0;
    end else begin
      m_err = 0;
      ohs_m = e_ov & out_ready;
      if (!m_busy) begin
        if (sv && ssop) begin
          m_busy = 1;
          m_pad  = 0;
        end else begin
          m_act = sel_req;
        end
      end else if (clash) begin
        m_pad = 1;
        m_err = 1;
      end else if (ohs_m) begin
        if (m_pos == LASTI) begin
          if (!m_pad && !seop) m_err = 1;
          m_pos  = 0;
          m_fc   = (m_fc + 1) % 65536;
          m_act  = sel_req;
          m_busy = 0;
          m_pad  = 0;
        end else begin
          m_pos++;
          if (!m_pad && seop) begin
            m_pad = 1;
            m_err = 1;
          end
        end
      end
    end

    @(posedge clk);
    #1;
    if (acc0 && q0.size() > 0) void'(q0.pop_front());
    if (acc1 && q1.size() > 0) void'(q1.pop_front());
    if (bp_on) begin
      out_ready = rdy_seq[pat_idx];
      pat_idx   = (pat_idx + 1) % 4;
    end else begin
      out_ready = 1'b1;
    end
    drive();
  endtask

  task automatic wait_got(input int n, input string name);
    int c = 0;
    while (got.size() < n && c < 200) begin
      tick();
      c++;
    end
    check(name, 64'(got.size()), 64'(n));
  endtask

  task automatic wait_drain(input string name);
    int c = 0;
    while ((q0.size() + q1.size()) > 0 && c < 200) begin
      tick();
      c++;
    end
    check(name, 64'(q0.size() + q1.size()), 64'd0);
  endtask

  task automatic new_scenario();
    got.delete();
    err_seen = 0;
  endtask

  initial begin
    reset     = 1'b0;
    sel_req   = 1'b0;
    out_ready = 1'b1;
    drive();
    repeat (3) tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_frame_count", 64'(frame_count), 64'd0);
    check("rst_active_src", 64'(active_src), 64'd0);
    check("rst_err", 64'(err_frame), 64'd0);
    reset = 1'b1;
    repeat (2) tick();

    // Clean frame
    new_scenario();
    push_frame(0, 8, 'h100, 7);
    wait_got(8, "clean_beats");
    repeat (2) tick();
    check("clean_sop0", 64'(got[0].sop), 64'd1);
    check("clean_eop7", 64'(got[7].eop), 64'd1);
    check("clean_data3", 64'(got[3].data), 64'h103);
    check("clean_fc", 64'(frame_count), 64'd1);
    check("clean_err", 64'(err_seen), 64'd0);

    // Backpressure 1,0,0,1
    new_scenario();
    bp_on = 1;
    pat_idx = 0;
    push_frame(0, 8, 'h100, 7);
    wait_got(8, "bp_beats");
    bp_on = 0;
    repeat (3) tick();
    for (int i = 0; i < 8; i++) check("bp_data", 64'(got[i].data), 64'h100 + 64'(i));
    check("bp_fc", 64'(frame_count), 64'd2);
    check("bp_count", 64'(got.size()), 64'd8);

    // Short frame, eop on beat 4
    new_scenario();
    push_frame(0, 5, 'h100, 4);
    wait_got(8, "short_beats");
    repeat (2) tick();
    check("short_data4", 64'(got[4].data), 64'h104);
    check("short_eop4", 64'(got[4].eop), 64'd0);
    check("short_pad5", 64'(got[5].data), 64'd0);
    check("short_pad7", 64'(got[7].data), 64'd0);
    check("short_eop7", 64'(got[7].eop), 64'd1);
    check("short_err", 64'(err_seen), 64'd1);
    check("short_fc", 64'(frame_count), 64'd3);

    // Long frame, no eop, two extra beats flushed
    new_scenario();
    push_frame(0, 10, 'h100, -1);
    wait_got(8, "long_beats");
    wait_drain("long_flush");
    repeat (2) tick();
    check("long_eop7", 64'(got[7].eop), 64'd1);
    check("long_data7", 64'(got[7].data), 64'h107);
    check("long_err", 64'(err_seen), 64'd1);
    check("long_fc", 64'(frame_count), 64'd4);
    check("long_count", 64'(got.size()), 64'd8);

    // Mid-frame sop at beat 3
    new_scenario();
    push_frame(0, 3, 'h100, -1);
    push_frame(0, 8, 'h300, 7);
    wait_got(16, "midsop_beats");
    repeat (2) tick();
    check("midsop_pad3", 64'(got[3].data), 64'd0);
    check("midsop_pad7", 64'(got[7].data), 64'd0);
    check("midsop_eop7", 64'(got[7].eop), 64'd1);
    check("midsop_new0", 64'(got[8].data), 64'h300);
    check("midsop_newsop", 64'(got[8].sop), 64'd1);
    check("midsop_neweop", 64'(got[15].eop), 64'd1);
    check("midsop_err", 64'(err_seen), 64'd1);
    check("midsop_fc", 64'(frame_count), 64'd6);

    // Source switch requested at beat 2
    new_scenario();
    push_frame(0, 8, 'h100, 7);
    push_frame(1, 8, 'h200, 7);
    begin
      int c = 0;
      while (got.size() < 16 && c < 200) begin
        if (got.size() >= 2) sel_req = 1'b1;
        tick();
        c++;
      end
      check("switch_beats", 64'(got.size()), 64'd16);
    end
    repeat (2) tick();
    check("switch_last0", 64'(got[7].data), 64'h107);
    check("switch_first1", 64'(got[8].data), 64'h200);
    check("switch_sop1", 64'(got[8].sop), 64'd1);
    check("switch_act", 64'(active_src), 64'd1);
    check("switch_fc", 64'(frame_count), 64'd8);

    // Reset at beat 5
    new_scenario();
    push_frame(1, 8, 'h400, 7);
    wait_got(5, "rstmid_beats");
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("rstmid_valid", 64'(out_valid), 64'd0);
    check("rstmid_fc", 64'(frame_count), 64'd0);
    check("rstmid_act", 64'(active_src), 64'd0);
    wait_drain("rstmid_flush");
    new_scenario();
    push_frame(1, 8, 'h500, 7);
    wait_got(8, "post_beats");
    repeat (2) tick();
    check("post_sop0", 64'(got[0].sop), 64'd1);
    check("post_data0", 64'(got[0].data), 64'h500);
    check("post_eop7", 64'(got[7].eop), 64'd1);
    check("post_fc", 64'(frame_count), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_stream_arbiter.md
# frame_stream_arbiter

Sits between two Avalon-ST pixel producers and the VGA output stream. It grants the stream to one source at a time and switches sources only on frame boundaries. It regenerates start/end-of-packet framing from its own pixel counter. Malformed source frames are repaired: black pixels pad a short frame, and an overlong frame is truncated. The VGA consumer therefore always receives exactly WIDTH×HEIGHT beats per packet.

## Interface
Parameters:
- WIDTH, 640, pixels per line
- HEIGHT, 480, lines per frame
- DATA_W, 30, pixel width (10:10:10 RGB)

Ports (one clock; `reset` is synchronous and active-low):
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- sel_req  in  1  requested source (0 = src0, 1 = src1)
- src0_data / src1_data  in  DATA_W  source pixel
- src0_valid / src1_valid  in  1  source beat valid
- src0_sop / src1_sop  in  1  source start of packet
- src0_eop / src1_eop  in  1  source end of packet
- src0_ready / src1_ready  out  1  beat accepted from source
- out_data  out  DATA_W  pixel to the VGA stream
- out_valid  out  1  output beat valid
- out_sop  out  1  first pixel of frame
- out_eop  out  1  last pixel of frame
- out_ready  in  1  downstream ready
- active_src  out  1  currently granted source
- frame_count  out  16  count of completed output frames, wraps
- err_frame  out  1  one-cycle pulse on a malformed source frame

## Operation
- LAST = WIDTH*HEIGHT-1. `cnt` is $clog2(WIDTH*HEIGHT) bits wide.
- Output handshake (`ohs`) = out_valid & out_ready. Source handshake = src_valid & src_ready.
- The unselected source always has its ready driven to 0.
- States:
  - IDLE:
    - active_src loads sel_req every cycle.
    - out_valid = 0.
    - Selected ready = ~src_sop, so non-sop beats are flushed and discarded.
    - A valid sop beat is not consumed; the block moves to STREAM.
  - STREAM:
    - out_valid = src_valid. out_data = src_data. src_ready = out_ready.
    - out_sop = (cnt==0). out_eop = (cnt==LAST).
    - Each `ohs` increments cnt.
  - PAD:
    - out_valid = 1. out_data = 0. src_ready = 0.
    - out_sop = (cnt==0). out_eop = (cnt==LAST).
    - cnt increments on each `ohs`.
- Transitions and boundaries:
  - `ohs` at cnt==LAST, from either STREAM or PAD: cnt←0, frame_count+1, active_src←sel_req, go to IDLE. Any remaining source beats are flushed in IDLE.
  - STREAM, src_eop accepted with cnt<LAST: the beat is passed (out_eop=0), err_frame pulses, go to PAD.
  - STREAM, src_valid & src_sop with cnt≠0: the beat is not consumed and out_valid is forced to 0 that cycle. err_frame pulses, go to PAD. IDLE will then pick up that sop.
  - STREAM, `ohs` at cnt==LAST without src_eop: out_eop is still asserted and err_frame pulses.
  - A sel_req change mid-frame has no effect until the frame completes.
  - The sop beat in STREAM at cnt==0 is the normal case and is not an error.
- Reset (reset=0 on a rising clk edge):
  - state=IDLE, cnt=0, active_src=0, frame_count=0, err_frame=0.
  - All readies are 0 and out_valid=0 while reset is low.
  - Reset mid-frame cuts the output immediately. A partial frame reaching downstream is accepted behaviour.

## Timing
- Zero-cycle combinational pass-through from source to output in STREAM, including ready.
- State, cnt, frame_count and active_src are registered and update on the clk edge of the qualifying handshake.
- err_frame is registered: it is high for exactly one cycle after the detecting edge.
- out_data is held stable while out_valid=1 and out_ready=0:
  - In PAD the pixel is constant.
  - In STREAM this holds provided the source obeys Avalon-ST.
- The IDLE→STREAM entry costs one cycle in which the sop beat is visible but not consumed.

## Structure
- Shared package `vga_stream_pkg`:
  - state enum (IDLE, STREAM, PAD)
  - default WIDTH/HEIGHT/DATA_W constants
  - black-pixel constant
- One sub-module, `frame_pixel_counter`:
  - ports: clk, reset, inc, clr
  - outputs: cnt, is_first, is_last
  - parameterised by WIDTH, HEIGHT
- Source muxing and the FSM stay in the top module.

## Test plan
All scenarios use WIDTH=4, HEIGHT=2 (LAST=7).
- Clean frame: src0 sends 8 beats with sop on beat 0 and eop on beat 7, out_ready=1.
  - Expect 8 output beats with identical data, out_sop on beat 0 and out_eop on beat 7.
  - frame_count=1, err_frame never asserted.
- Backpressure: the same frame with out_ready toggling 1,0,0,1.
  - Expect src0_ready to mirror out_ready and out_data to be stable during stalls.
  - Still exactly 8 output handshakes.
- Short frame: src0 eop on beat 4.
  - Output beats 0–4 carry source data; beats 5–7 are 0 with out_eop on beat 7.
  - err_frame pulses once; frame_count=1.
- Long frame and mid-frame sop:
  - src0 with no eop by beat 7: out_eop is forced on beat 7, err_frame pulses, and extra non-sop beats are flushed (src0_ready=1, out_valid=0).
  - src0 sop at beat 3: pad beats 3–7 are 0, then a new frame starts from that sop.
- Switch: sel_req 0→1 at beat 2 of a src0 frame.
  - The src0 frame completes; active_src becomes 1 after beat 7.
  - src1_ready=0 throughout; the next frame comes from src1.
- Reset mid-frame: reset=0 at beat 5.
  - The next cycle has out_valid=0, cnt=0, frame_count=0, active_src=0.
